// File: rtl/valid_ready_serializer_if.sv
// Wide-in / narrow-out valid-ready bundle for valid_ready_serializer.
// slave  : serializer side (consumes write_*, produces read_*).
// master : environment side (produces write_*, consumes read_*).
interface valid_ready_serializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
);
    logic [WIDTH*RATIO-1:0] write_data;
    logic                   write_valid;
    logic                   write_ready;
    logic [WIDTH-1:0]       read_data;
    logic                   read_valid;
    logic                   read_ready;
    logic                   read_last;

    modport slave (
        input  write_data,
        input  write_valid,
        output write_ready,
        output read_data,
        output read_valid,
        input  read_ready,
        output read_last
    );

    modport master (
        output write_data,
        output write_valid,
        input  write_ready,
        input  read_data,
        input  read_valid,
        output read_ready,
        input  read_last
    );
endinterface

// File: rtl/valid_ready_serializer.sv
// Wide-to-narrow valid-ready serializer: one WIDTH*RATIO word in, RATIO
// WIDTH-bit beats out, read_last on the final beat, no bubble between words.
// Build option: define VALID_READY_SERIALIZER_MSB_FIRST_EN to emit the most
// significant beat first (default is least significant beat first).
module valid_ready_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    output logic                          busy,
    valid_ready_serializer_if.slave       bus
);
    localparam int unsigned COUNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_SENDING = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [RATIO-1:0][WIDTH-1:0]   r_data;
    logic [COUNT_WIDTH-1:0]        r_cnt;
    logic [COUNT_WIDTH-1:0]        w_beat_idx;
    logic                          w_write_en;
    logic                          w_read_en;
    logic                          w_cnt_last;

    assign w_cnt_last = (r_cnt == LAST_CNT);
    assign w_write_en = bus.write_valid & bus.write_ready;
    assign w_read_en  = bus.read_valid & bus.read_ready;

`ifdef VALID_READY_SERIALIZER_MSB_FIRST_EN
    assign w_beat_idx = LAST_CNT - r_cnt;
`else
    assign w_beat_idx = r_cnt;
`endif

    // State register: EMPTY until a word is loaded, SENDING while beats remain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a load on the last-beat edge keeps the serializer in SENDING.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_write_en) begin
                    w_state_nxt = ST_SENDING;
                end
            end
            ST_SENDING: begin
                if (w_read_en && w_cnt_last && !w_write_en) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Outputs: valid/last follow the state; write_ready also opens on the last-beat handshake.
    always_comb begin
        busy            = (r_state == ST_SENDING);
        bus.read_valid  = busy;
        bus.read_last   = busy & w_cnt_last;
        bus.write_ready = ~busy | (w_read_en & w_cnt_last);
        bus.read_data   = r_data[w_beat_idx];
    end

    // Holding register and beat counter; the word is only replaced on a write handshake.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_write_en) begin
                r_data <= bus.write_data;
                r_cnt  <= '0;
            end else if (w_read_en) begin
                if (w_cnt_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_valid_ready_serializer.sv
// Self-checking bench for valid_ready_serializer (WIDTH=8/RATIO=4 main
// instance, WIDTH=4/RATIO=3 secondary instance). Beat order follows
// VALID_READY_SERIALIZER_MSB_FIRST_EN when defined.
module tb_valid_ready_serializer;
    logic clock;
    logic resetn;
    logic busy;
    logic busy3;

    valid_ready_serializer_if #(.WIDTH(8), .RATIO(4)) bus ();
    valid_ready_serializer_if #(.WIDTH(4), .RATIO(3)) bus3 ();

    valid_ready_serializer #(.WIDTH(8), .RATIO(4)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .busy   (busy),
        .bus    (bus.slave)
    );

    valid_ready_serializer #(.WIDTH(4), .RATIO(3)) u_dut3 (
        .clock  (clock),
        .resetn (resetn),
        .busy   (busy3),
        .bus    (bus3.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned beat_idx(input int unsigned k, input int unsigned ratio);
`ifdef VALID_READY_SERIALIZER_MSB_FIRST_EN
        return ratio - 1 - k;
`else
        return k;
`endif
    endfunction

    // Scoreboard of expected beats for the main instance
    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;
    beat_t sb[$];

    function automatic void push_word(input logic [31:0] w);
        beat_t b;
        for (int unsigned k = 0; k < 4; k++) begin
            b.data = w[beat_idx(k, 4)*8 +: 8];
            b.last = (k == 3);
            sb.push_back(b);
        end
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            sb.delete();
        end else begin
            if (bus.read_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none t=%0t", bus.read_data, $time);
                end else begin
                    chk("beat_data", 64'(bus.read_data), 64'(sb[0].data));
                    chk("beat_last", 64'(bus.read_last), 64'(sb[0].last));
                    if (bus.read_ready) void'(sb.pop_front());
                end
            end
            if (bus.write_valid && bus.write_ready) push_word(bus.write_data);
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [7:0]  pat;
        int unsigned exp_cyc;
        string       name;
    } vec_t;
    vec_t vecs[4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One word with a repeating read_ready pattern; checks duration and write_ready
    task automatic run_vec(input vec_t v);
        int unsigned cyc;
        int unsigned ones;
        bus.write_data  = v.word;
        bus.write_valid = 1'b1;
        bus.read_ready  = 1'b0;
        @(negedge clock);
        chk({v.name, "_ready_idle"}, 64'(bus.write_ready), 64'd1);
        step();
        bus.write_valid = 1'b0;
        bus.write_data  = '1;
        cyc  = 0;
        ones = 0;
        while (busy && cyc < 64) begin
            bus.read_ready = v.pat[cyc % 8];
            @(negedge clock);
            chk({v.name, "_wready"}, 64'(bus.write_ready), 64'(bus.read_ready && ones == 3));
            if (bus.read_ready) ones++;
            step();
            cyc++;
        end
        chk({v.name, "_cycles"}, 64'(cyc), 64'(v.exp_cyc));
        bus.read_ready = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        int          acc;
        logic [11:0] w3;

        vecs[0] = '{word: 32'hDDCCBBAA, pat: 8'hFF, exp_cyc: 4, name: "full_rate"};
        vecs[1] = '{word: 32'hDDCCBBAA, pat: 8'h69, exp_cyc: 7, name: "stall_toggle"};
        vecs[2] = '{word: 32'h12345678, pat: 8'h55, exp_cyc: 7, name: "alt_ready"};
        vecs[3] = '{word: 32'hCAFEF00D, pat: 8'hAA, exp_cyc: 8, name: "late_ready"};

        resetn           = 1'b0;
        bus.write_data   = '0;
        bus.write_valid  = 1'b0;
        bus.read_ready   = 1'b0;
        bus3.write_data  = '0;
        bus3.write_valid = 1'b0;
        bus3.read_ready  = 1'b0;
        #3;
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_rvalid", 64'(bus.read_valid), 64'd0);
        chk("rst_last",   64'(bus.read_last), 64'd0);
        chk("rst_wready", 64'(bus.write_ready), 64'd1);
        chk("rst_rdata",  64'(bus.read_data), 64'd0);
        step();
        step();
        resetn = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back words with write_valid and read_ready held high
        bus.write_data  = 32'h44332211;
        bus.write_valid = 1'b1;
        bus.read_ready  = 1'b1;
        step();
        bus.write_data = 32'h88776655;
        cyc = 0;
        acc = -1;
        while (busy && cyc < 40) begin
            @(negedge clock);
            chk("b2b_rvalid", 64'(bus.read_valid), 64'd1);
            if (bus.write_valid && bus.write_ready && acc < 0) acc = int'(cyc);
            step();
            if (acc >= 0) bus.write_valid = 1'b0;
            cyc++;
        end
        chk("b2b_accept_cycle", 64'(acc), 64'd3);
        chk("b2b_total_cycles", 64'(cyc), 64'd8);
        bus.read_ready = 1'b0;
        step();

        // Reset in the middle of a word
        bus.write_data  = 32'hDDCCBBAA;
        bus.write_valid = 1'b1;
        bus.read_ready  = 1'b1;
        step();
        bus.write_valid = 1'b0;
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(bus.read_valid), 64'd0);
        chk("mid_rst_busy",   64'(busy), 64'd0);
        chk("mid_rst_rdata",  64'(bus.read_data), 64'd0);
        chk("mid_rst_wready", 64'(bus.write_ready), 64'd1);
        step();
        step();
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_rvalid", 64'(bus.read_valid), 64'd0);
        step();
        bus.write_data  = 32'h01020304;
        bus.write_valid = 1'b1;
        step();
        bus.write_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            step();
            cyc++;
        end
        chk("post_rst_cycles", 64'(cyc), 64'd4);
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        bus.read_ready = 1'b0;

        // RATIO=3, WIDTH=4 instance with a continuous stream of one word
        w3 = 12'h321;
        bus3.write_data  = w3;
        bus3.write_valid = 1'b1;
        bus3.read_ready  = 1'b1;
        step();
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("r3_rvalid", 64'(bus3.read_valid), 64'd1);
            chk("r3_data",   64'(bus3.read_data), 64'(w3[beat_idx(k % 3, 3)*4 +: 4]));
            chk("r3_last",   64'(bus3.read_last), 64'(k % 3 == 2));
            chk("r3_wready", 64'(bus3.write_ready), 64'(k % 3 == 2));
        end
        bus3.write_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
